// File: rtl/ts_frame_sink_if.sv
// Byte-stream bundle for the transport-stream frame sink: framed input
// stream in, clean TS packet stream out.
interface ts_frame_sink_if;
  logic [7:0] iData;
  logic       iValid;
  logic       iPSync;
  logic [7:0] oData;
  logic       oValid;
  logic       oPSync;

  // Stream source / consumer side (drives the framed input, observes output)
  modport master (
    output iData, iValid, iPSync,
    input  oData, oValid, oPSync
  );

  // Frame sink side
  modport slave (
    input  iData, iValid, iPSync,
    output oData, oValid, oPSync
  );
endinterface

// File: rtl/ts_frame_sink.sv
// Transport-stream frame sink: tracks 204-byte frame alignment on the 0x47
// sync byte, strips the 16 gap bytes, optionally drops null packets and
// delivers 188-byte TS packets with a start flag, lock status and counters.
module ts_frame_sink #(
  parameter int LOCK_FRAMES = 2,
  parameter int MISS_FRAMES = 3,
  parameter bit DROP_NULL   = 1'b1
) (
  input  logic            iClk,
  input  logic            iRst,
  ts_frame_sink_if.slave  bus,
  output logic            oLock,
  output logic [15:0]     oPktCnt,
  output logic [15:0]     oNullCnt,
  output logic [7:0]      oSyncErrCnt
);

  localparam logic [1:0]  ST_HUNT     = 2'd0;
  localparam logic [1:0]  ST_VERIFY   = 2'd1;
  localparam logic [1:0]  ST_LOCK     = 2'd2;
  localparam logic [7:0]  SYNC_BYTE   = 8'h47;
  localparam logic [7:0]  LAST_POS    = 8'd203;
  localparam logic [7:0]  LAST_TS_POS = 8'd187;
  localparam logic [12:0] NULL_PID    = 13'h1FFF;
  localparam logic [3:0]  LOCK_N      = 4'(LOCK_FRAMES);
  localparam logic [3:0]  MISS_N      = 4'(MISS_FRAMES);

  function automatic logic [7:0] next_pos(input logic [7:0] p);
    next_pos = (p == LAST_POS) ? 8'd0 : p + 8'd1;
  endfunction

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    sat_inc8 = (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  function automatic logic [15:0] wrap_inc16(input logic [15:0] v);
    wrap_inc16 = v + 16'd1;
  endfunction

  // Alignment tracking and packet bookkeeping
  logic [1:0]  state_q, state_d;
  logic [7:0]  pos_q, pos_d;
  logic [3:0]  goodcnt_q, goodcnt_d;
  logic [3:0]  misscnt_q, misscnt_d;
  logic        pkt_elig_q, pkt_elig_d;
  logic        pkt_drop_q, pkt_drop_d;
  logic [4:0]  pid_hi_q, pid_hi_d;
  logic [15:0] pkt_cnt_q, pkt_cnt_d;
  logic [15:0] null_cnt_q, null_cnt_d;
  logic [7:0]  err_cnt_q, err_cnt_d;

  // Three-entry delay line {data, pos, eligible}
  logic [7:0]  data_p0_q, data_p0_d, data_p1_q, data_p1_d, data_p2_q, data_p2_d;
  logic [7:0]  pos_p0_q, pos_p0_d, pos_p1_q, pos_p1_d, pos_p2_q, pos_p2_d;
  logic        elig_p0_q, elig_p0_d, elig_p1_q, elig_p1_d, elig_p2_q, elig_p2_d;

  // Registered output stage
  logic [7:0]  odata_q, odata_d;
  logic        ovalid_q, ovalid_d;
  logic        opsync_q, opsync_d;

  logic        sync_good;
  logic [7:0]  byte_pos;
  logic        elig_now;
  logic [3:0]  goodcnt_inc;
  logic [3:0]  misscnt_inc;
  logic        deliver;

  // Next-state: sync FSM, flywheel counter, packet qualify, pipeline shift
  always_comb begin
    state_d    = state_q;
    pos_d      = pos_q;
    goodcnt_d  = goodcnt_q;
    misscnt_d  = misscnt_q;
    pkt_elig_d = pkt_elig_q;
    pkt_drop_d = pkt_drop_q;
    pid_hi_d   = pid_hi_q;
    pkt_cnt_d  = pkt_cnt_q;
    null_cnt_d = null_cnt_q;
    err_cnt_d  = err_cnt_q;
    data_p0_d  = data_p0_q;
    data_p1_d  = data_p1_q;
    data_p2_d  = data_p2_q;
    pos_p0_d   = pos_p0_q;
    pos_p1_d   = pos_p1_q;
    pos_p2_d   = pos_p2_q;
    elig_p0_d  = elig_p0_q;
    elig_p1_d  = elig_p1_q;
    elig_p2_d  = elig_p2_q;
    odata_d    = 8'h00;
    ovalid_d   = 1'b0;
    opsync_d   = 1'b0;

    sync_good   = bus.iPSync && (bus.iData == SYNC_BYTE);
    byte_pos    = pos_q;
    elig_now    = pkt_elig_q;
    goodcnt_inc = goodcnt_q + 4'd1;
    misscnt_inc = misscnt_q + 4'd1;
    // Packet still delivered at the exit: eligible, not a dropped null, not gap.
    deliver     = elig_p2_q && !pkt_drop_q && (pos_p2_q <= LAST_TS_POS);

    if (bus.iValid) begin
      pos_d = next_pos(pos_q);
      case (state_q)
        ST_HUNT: begin
          // Any good sync is an acquisition, regardless of the flywheel.
          if (sync_good) begin
            byte_pos  = 8'd0;
            pos_d     = 8'd1;
            goodcnt_d = 4'd1;
            misscnt_d = 4'd0;
            if (LOCK_N <= 4'd1) begin
              state_d  = ST_LOCK;
              elig_now = 1'b1;
            end else begin
              state_d  = ST_VERIFY;
              elig_now = 1'b0;
            end
          end else begin
            elig_now = 1'b0;
          end
        end
        ST_VERIFY: begin
          if (pos_q == 8'd0) begin
            if (sync_good) begin
              goodcnt_d = goodcnt_inc;
              if (goodcnt_inc >= LOCK_N) begin
                state_d  = ST_LOCK;
                elig_now = 1'b1;
              end else begin
                elig_now = 1'b0;
              end
            end else begin
              state_d   = ST_HUNT;
              goodcnt_d = 4'd0;
              elig_now  = 1'b0;
            end
          end
        end
        ST_LOCK: begin
          if (pos_q == 8'd0) begin
            if (sync_good) begin
              misscnt_d = 4'd0;
              elig_now  = 1'b1;
            end else begin
              // Suppress the whole frame but keep the flywheel running.
              err_cnt_d = sat_inc8(err_cnt_q);
              misscnt_d = misscnt_inc;
              elig_now  = 1'b0;
              if (misscnt_inc >= MISS_N) begin
                state_d   = ST_HUNT;
                goodcnt_d = 4'd0;
                misscnt_d = 4'd0;
              end
            end
          end
        end
        default: begin
          state_d  = ST_HUNT;
          elig_now = 1'b0;
        end
      endcase

      pkt_elig_d = elig_now;
      if (byte_pos == 8'd0) pkt_drop_d = 1'b0;
      if (byte_pos == 8'd1) pid_hi_d = bus.iData[4:0];
      if ((byte_pos == 8'd2) && elig_now) begin
        if (DROP_NULL && ({pid_hi_q, bus.iData} == NULL_PID)) begin
          pkt_drop_d = 1'b1;
          null_cnt_d = wrap_inc16(null_cnt_q);
        end else begin
          pkt_drop_d = 1'b0;
          pkt_cnt_d  = wrap_inc16(pkt_cnt_q);
        end
      end

      data_p0_d = bus.iData;
      pos_p0_d  = byte_pos;
      elig_p0_d = elig_now;
      data_p1_d = data_p0_q;
      pos_p1_d  = pos_p0_q;
      elig_p1_d = elig_p0_q;
      data_p2_d = data_p1_q;
      pos_p2_d  = pos_p1_q;
      elig_p2_d = elig_p1_q;

      if (deliver) begin
        odata_d  = data_p2_q;
        ovalid_d = 1'b1;
        opsync_d = (pos_p2_q == 8'd0);
      end
    end
  end

  // Control state, counters and output register with synchronous reset
  always_ff @(posedge iClk) begin
    if (iRst) begin
      state_q    <= ST_HUNT;
      pos_q      <= 8'd0;
      goodcnt_q  <= 4'd0;
      misscnt_q  <= 4'd0;
      pkt_elig_q <= 1'b0;
      pkt_drop_q <= 1'b0;
      pkt_cnt_q  <= 16'd0;
      null_cnt_q <= 16'd0;
      err_cnt_q  <= 8'd0;
      elig_p0_q  <= 1'b0;
      elig_p1_q  <= 1'b0;
      elig_p2_q  <= 1'b0;
      odata_q    <= 8'h00;
      ovalid_q   <= 1'b0;
      opsync_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      pos_q      <= pos_d;
      goodcnt_q  <= goodcnt_d;
      misscnt_q  <= misscnt_d;
      pkt_elig_q <= pkt_elig_d;
      pkt_drop_q <= pkt_drop_d;
      pkt_cnt_q  <= pkt_cnt_d;
      null_cnt_q <= null_cnt_d;
      err_cnt_q  <= err_cnt_d;
      elig_p0_q  <= elig_p0_d;
      elig_p1_q  <= elig_p1_d;
      elig_p2_q  <= elig_p2_d;
      odata_q    <= odata_d;
      ovalid_q   <= ovalid_d;
      opsync_q   <= opsync_d;
    end
  end

  // Data payload of the delay line and PID capture; qualified by control bits
  always_ff @(posedge iClk) begin
    pid_hi_q  <= pid_hi_d;
    data_p0_q <= data_p0_d;
    data_p1_q <= data_p1_d;
    data_p2_q <= data_p2_d;
    pos_p0_q  <= pos_p0_d;
    pos_p1_q  <= pos_p1_d;
    pos_p2_q  <= pos_p2_d;
  end

  assign bus.oData   = odata_q;
  assign bus.oValid  = ovalid_q;
  assign bus.oPSync  = opsync_q;
  assign oLock       = (state_q == ST_LOCK);
  assign oPktCnt     = pkt_cnt_q;
  assign oNullCnt    = null_cnt_q;
  assign oSyncErrCnt = err_cnt_q;

endmodule
